// File: rtl/result_pkg.sv
// Shared frame layout for the result sampler: field widths, offsets and the
// packed {tag, frame} entry stored in the FIFO.
package result_pkg;

    localparam int S1_W    = 8;
    localparam int S2_W    = 16;
    localparam int FRAME_W = 24;
    localparam int TAG_W   = 4;
    localparam int S1_LSB  = 16;
    localparam int S2_LSB  = 0;
    localparam int ENTRY_W = TAG_W + FRAME_W;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [FRAME_W-1:0] frame;
    } entry_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [S1_W-1:0] s1,
        input logic [S2_W-1:0] s2
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[S1_LSB +: S1_W] = s1;
        f[S2_LSB +: S2_W] = s2;
        return f;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead FIFO: head entry is read combinationally from storage, so a word
// written at edge k is presented right after edge k.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Entries are cleared on reset so the head reads zero until the first push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (!rst) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/result_sampler_fifo.sv
// Decimating sampler: every DECIM enabled cycles packs {s1,s2} with a sequence
// tag into a FIFO drained over valid/ready; sticky overflow flags drops.
module result_sampler_fifo #(
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [7:0]             s1,
    input  logic [15:0]            s2,
    input  logic                   clr_ovf,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [23:0]            out_data,
    output logic [3:0]             out_tag,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    import result_pkg::*;

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CNT_W-1:0]   dcnt_reg;
    logic [TAG_W-1:0]   seq_reg;
    logic               overflow_reg;
    logic               strobe;
    logic               pop;
    logic               push;
    logic               drop;
    logic               full;
    logic               empty;
    entry_t             wr_entry;
    entry_t             head_entry;
    logic [ENTRY_W-1:0] head_bits;

    assign strobe = en && (dcnt_reg == CNT_W'(DECIM - 1));
    assign pop    = !empty && out_ready;
    // A full FIFO can still accept the sample if the head leaves this cycle.
    assign push   = strobe && (!full || pop);
    assign drop   = strobe && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dcnt_reg <= '0;
        end else if (en) begin
            dcnt_reg <= strobe ? '0 : dcnt_reg + 1'b1;
        end
    end

    // Tag advances on every strobe, dropped or not, so gaps expose losses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seq_reg <= '0;
        end else if (strobe) begin
            seq_reg <= seq_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.tag   = seq_reg;
        wr_entry.frame = pack_frame(s1, s2);
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head_bits),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign head_entry = head_bits;
    assign out_valid  = !empty;
    assign out_data   = head_entry.frame;
    assign out_tag    = head_entry.tag;
    assign overflow   = overflow_reg;

endmodule
